// File: rtl/mosby_pkg.sv
// Shared definitions for the interrupt sequencer: the sequencer state
// encoding, default vector and stack-page addresses, 6502 status bit indices,
// and a helper that forms the status byte pushed to the stack.
package mosby_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST0,
    ST_RST1,
    ST_RST2,
    ST_PCH,
    ST_PCL,
    ST_PSH,
    ST_VLO,
    ST_VHI,
    ST_LOAD
  } seq_state_t;

  localparam logic [15:0] DEF_VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RST    = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // Status as it appears on the stack: U always 1, B reflects the cause.
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic b);
    logic [7:0] r;
    r      = p;
    r[P_U] = 1'b1;
    r[P_B] = b;
    return r;
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI falling-edge detector with a pending latch. A new edge arriving in the
// same cycle as a clear request keeps the latch set so no NMI is lost.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic clear,
  output logic nmi_pend
);

  logic nmi_prev;

  // Sample the line every cycle; set on a 1->0 transition, set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      if (nmi_prev && !nmi_n) begin
        nmi_pend <= 1'b1;
      end else if (clear) begin
        nmi_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset / NMI / IRQ / BRK micro-sequencer. Owns the bus while busy=1,
// pushes PCH, PCL and P, fetches the vector and loads the program counter.
// Optional macro NMI_HIJACK_EN: an NMI that becomes pending during the pushes
// of an IRQ/BRK sequence redirects that sequence to the NMI vector.
module interrupt_sequencer
  import mosby_pkg::*;
#(
  parameter logic [15:0] VEC_NMI    = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RST    = DEF_VEC_RST,
  parameter logic [15:0] VEC_IRQ    = DEF_VEC_IRQ,
  parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_boundary,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        i_flag,
  input  logic [15:0] pc,
  input  logic [7:0]  status,
  input  logic [7:0]  sp,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        w_rd,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic        set_i,
  output logic        done
);

  seq_state_t  state_reg, state_next;
  logic [15:0] pc_save_reg;
  logic [7:0]  p_save_reg;
  logic [15:0] vec_reg;
  logic        vec_nmi_reg;
  logic        b_reg;
  logic [7:0]  vlo_reg, vhi_reg;

  logic nmi_pend;
  logic nmi_clear;
  logic hijack;
  logic start;

  nmi_edge_detect u_nmi (
    .clk      (clk),
    .rst      (rst),
    .nmi_n    (nmi_n),
    .clear    (nmi_clear),
    .nmi_pend (nmi_pend)
  );

  // Any cause present at an instruction boundary starts a sequence.
  assign start = instr_boundary && (nmi_pend || brk_req || (!irq_n && !i_flag));

  assign pc_load_value = {vhi_reg, vlo_reg};

  // Next-state and bus outputs; reset overrides force a quiet, busy bus.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    addr       = {STACK_PAGE, sp};
    data_out   = 8'h00;
    w_rd       = 1'b0;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    done       = 1'b0;
    nmi_clear  = 1'b0;
    hijack     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_PCH;
      end
      ST_RST0: begin sp_dec = 1'b1; state_next = ST_RST1; end
      ST_RST1: begin sp_dec = 1'b1; state_next = ST_RST2; end
      ST_RST2: begin sp_dec = 1'b1; state_next = ST_VLO;  end
      ST_PCH: begin
        w_rd = 1'b1; sp_dec = 1'b1; data_out = pc_save_reg[15:8];
        state_next = ST_PCL;
      end
      ST_PCL: begin
        w_rd = 1'b1; sp_dec = 1'b1; data_out = pc_save_reg[7:0];
        state_next = ST_PSH;
      end
      ST_PSH: begin
        w_rd = 1'b1; sp_dec = 1'b1; data_out = push_status(p_save_reg, b_reg);
        state_next = ST_VLO;
`ifdef NMI_HIJACK_EN
        hijack = nmi_pend && !vec_nmi_reg;
`else
        hijack = 1'b0;
`endif
        // The NMI is consumed as its vector fetch begins.
        nmi_clear = vec_nmi_reg || hijack;
      end
      ST_VLO:  begin addr = vec_reg;          state_next = ST_VHI;  end
      ST_VHI:  begin addr = vec_reg + 16'd1;  state_next = ST_LOAD; end
      ST_LOAD: begin
        addr = pc_load_value; pc_load = 1'b1; set_i = 1'b1; done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!rst) begin
      busy     = 1'b1;
      addr     = {STACK_PAGE, sp};
      data_out = 8'h00;
      w_rd     = 1'b0;
      sp_dec   = 1'b0;
      pc_load  = 1'b0;
      set_i    = 1'b0;
      done     = 1'b0;
    end
  end

  // State register plus the values captured on entry, vector selection and
  // the two fetched vector bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_RST0;
      pc_save_reg <= 16'h0000;
      p_save_reg  <= 8'h00;
      vec_reg     <= 16'h0000;
      vec_nmi_reg <= 1'b0;
      b_reg       <= 1'b0;
      vlo_reg     <= 8'h00;
      vhi_reg     <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start) begin
        pc_save_reg <= pc;
        p_save_reg  <= status;
        if (nmi_pend) begin
          vec_reg     <= VEC_NMI;
          vec_nmi_reg <= 1'b1;
          b_reg       <= 1'b0;
        end else begin
          vec_reg     <= VEC_IRQ;
          vec_nmi_reg <= 1'b0;
          b_reg       <= brk_req;
        end
      end
      if (state_reg == ST_RST2) begin
        vec_reg     <= VEC_RST;
        vec_nmi_reg <= 1'b0;
      end
      if (hijack) begin
        vec_reg     <= VEC_NMI;
        vec_nmi_reg <= 1'b1;
      end
      if (state_reg == ST_VLO) vlo_reg <= data_in;
      if (state_reg == ST_VHI) vhi_reg <= data_in;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: memory and stack-pointer models around
// the DUT, expected bus traces built from the sequence rules, table vectors,
// hand-written corner sequences and randomized cases.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_boundary, nmi_n, irq_n, brk_req, i_flag;
  logic [15:0] pc;
  logic [7:0]  status, sp, data_in;
  logic        busy, w_rd, sp_dec, pc_load, set_i, done;
  logic [15:0] addr, pc_load_value;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .instr_boundary(instr_boundary), .nmi_n(nmi_n),
    .irq_n(irq_n), .brk_req(brk_req), .i_flag(i_flag), .pc(pc),
    .status(status), .sp(sp), .data_in(data_in), .busy(busy), .addr(addr),
    .data_out(data_out), .w_rd(w_rd), .sp_dec(sp_dec), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .set_i(set_i), .done(done)
  );

  logic [7:0] mem [0:65535];
  assign data_in = mem[addr];

  typedef struct packed {
    logic        busy;
    logic [15:0] addr;
    logic        w;
    logic [7:0]  data;
    logic        dec;
    logic        pcl;
    logic        seti;
    logic        done;
  } rec_t;

  typedef struct {
    logic        nmi, brk, irqn, iflag;
    logic [15:0] pcv;
    logic [7:0]  st, sp0;
    int          kind;
    logic [15:0] vec;
    logic [7:0]  pexp;
  } vec_t;

  rec_t        tr [8];
  rec_t        ex [8];
  rec_t        dummy;
  logic [15:0] plv_seen;
  logic [15:0] exp_tgt;
  logic [7:0]  exp_sp;
  int          exp_kind;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock: sample outputs, then apply memory write and SP decrement.
  task automatic step(output rec_t r);
    #1;
    r = {busy, addr, w_rd, data_out, sp_dec, pc_load, set_i, done};
    if (pc_load) plv_seen = pc_load_value;
    @(posedge clk);
    #1;
    if (r.w) mem[r.addr] = r.data;
    if (r.dec) sp = sp - 8'd1;
    @(negedge clk);
  endtask

  task automatic collect(input int nmi_at);
    plv_seen = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      if (c == nmi_at) nmi_n = 1'b0;
      step(tr[c]);
      if (c == 0) begin
        instr_boundary = 1'b0;
        brk_req        = 1'b0;
        irq_n          = 1'b1;
      end
    end
  endtask

  function automatic rec_t idle_rec(input logic [7:0] s);
    return {1'b0, 8'h01, s, 1'b0, 8'h00, 4'b0000};
  endfunction

  function automatic rec_t mk(input logic [15:0] a, input logic w, input logic [7:0] d,
                              input logic dec, input logic fin);
    return {1'b1, a, w, d, dec, fin, fin, fin};
  endfunction

  // kind 0: interrupt after a boundary cycle; 1: reset sequence; 2: no entry.
  task automatic build_exp(input int kind, input logic [15:0] vec, input logic [15:0] pcv,
                           input logic [7:0] p, input logic [7:0] sp0);
    logic [7:0] s;
    logic [7:0] pb [3];
    int         off;
    exp_kind = kind;
    s        = sp0;
    if (kind == 2) begin
      for (int i = 0; i < 8; i++) ex[i] = idle_rec(sp0);
      exp_sp = sp0;
    end else begin
      off   = (kind == 0) ? 1 : 0;
      pb[0] = pcv[15:8];
      pb[1] = pcv[7:0];
      pb[2] = p;
      if (kind == 0) ex[0] = idle_rec(sp0);
      for (int i = 0; i < 3; i++) begin
        ex[off+i] = mk({8'h01, s}, kind == 0, (kind == 0) ? pb[i] : 8'h00, 1'b1, 1'b0);
        s = s - 8'd1;
      end
      exp_tgt   = {mem[vec + 16'd1], mem[vec]};
      ex[off+3] = mk(vec, 1'b0, 8'h00, 1'b0, 1'b0);
      ex[off+4] = mk(vec + 16'd1, 1'b0, 8'h00, 1'b0, 1'b0);
      ex[off+5] = mk(exp_tgt, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = off + 6; i < 8; i++) ex[i] = idle_rec(s);
      exp_sp = s;
    end
  endtask

  task automatic compare(input string tag);
    for (int c = 0; c < 8; c++)
      check($sformatf("%s cyc%0d", tag, c), 32'(tr[c]), 32'(ex[c]));
    if (exp_kind != 2) check($sformatf("%s pc_load_value", tag), 32'(plv_seen), 32'(exp_tgt));
    check($sformatf("%s sp", tag), 32'(sp), 32'(exp_sp));
    $display("[TB] %s kind=%0d pcv=%h sp=%h", tag, exp_kind, plv_seen, sp);
  endtask

  task automatic run_case(input string tag, input vec_t v, input int nmi_at);
    if (v.nmi) begin
      nmi_n = 1'b0;
      step(dummy);
      nmi_n = 1'b1;
    end
    sp = v.sp0; pc = v.pcv; status = v.st;
    brk_req = v.brk; irq_n = v.irqn; i_flag = v.iflag; instr_boundary = 1'b1;
    build_exp(v.kind, v.vec, v.pcv, v.pexp, v.sp0);
    collect(nmi_at);
    compare(tag);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hA0;
    rst = 1'b0; instr_boundary = 1'b0; nmi_n = 1'b1; irq_n = 1'b1;
    brk_req = 1'b0; i_flag = 1'b1; pc = 16'h0000; status = 8'h00; sp = 8'hFD;

    //                nmi   brk   irqn  iflag pc        st     sp     kind vec       pexp
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hC010, 8'h81, 8'hF0, 0, 16'hFFFE, 8'hA1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 8'h04, 8'hF0, 2, 16'h0000, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1236, 8'h04, 8'hFF, 0, 16'hFFFE, 8'h34};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h2002, 8'h10, 8'h80, 0, 16'hFFFA, 8'h20};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD, 8'hFF, 8'h01, 0, 16'hFFFE, 8'hEF};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h7777, 8'h00, 8'h50, 2, 16'h0000, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 8'h04, 8'h40, 0, 16'hFFFA, 8'h24};

    // Reset held: quiet strobes, busy, stack address.
    @(negedge clk); @(negedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd1);
    check("rst addr", 32'(addr), 32'h01FD);
    check("rst strobes", 32'({w_rd, sp_dec, pc_load, set_i, done}), 32'd0);
    check("rst data_out", 32'(data_out), 32'd0);
    check("rst pc_load_value", 32'(pc_load_value), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    build_exp(1, 16'hFFFC, 16'h0000, 8'h00, 8'hFD);
    collect(-1);
    compare("reset");
    check("reset vector", 32'(plv_seen), 32'h1234);

    for (int i = 0; i < 7; i++) run_case($sformatf("tbl%0d", i), tbl[i], -1);

    // Reset asserted while pushing P: no write, then a full reset sequence.
    sp = 8'hC0; pc = 16'h4444; status = 8'h00; irq_n = 1'b0; i_flag = 1'b0;
    instr_boundary = 1'b1;
    step(dummy);
    instr_boundary = 1'b0; irq_n = 1'b1;
    step(dummy);
    step(dummy);
    #1;
    check("psh w_rd before rst", 32'(w_rd), 32'd1);
    rst = 1'b0;
    #1;
    check("psh rst strobes", 32'({w_rd, sp_dec, pc_load, set_i, done}), 32'd0);
    check("psh rst busy", 32'(busy), 32'd1);
    check("psh rst addr", 32'(addr), 32'h01BE);
    @(posedge clk);
    @(negedge clk);
    check("psh not written", 32'(mem[16'h01BE]), 32'd0);
    rst = 1'b1;
    build_exp(1, 16'hFFFC, 16'h0000, 8'h00, 8'hBE);
    collect(-1);
    compare("rst_after_psh");

    // NMI edge during PCL of an IRQ sequence.
    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 8'h00, 8'hF0, 0, 16'hFFFE, 8'h20};
`ifdef NMI_HIJACK_EN
    rv.vec = 16'hFFFA;
`endif
    run_case("nmi_in_pcl", rv, 2);
    nmi_n = 1'b1;
    rv = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h3100, 8'h01, 8'hE0, 0, 16'hFFFA, 8'h21};
`ifdef NMI_HIJACK_EN
    rv.kind = 2;
`endif
    run_case("after_nmi_in_pcl", rv, -1);

    // Randomized cases against the priority/vector rules.
    for (int i = 0; i < 24; i++) begin
      for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
      rv.nmi   = ($urandom_range(0, 3) == 0);
      rv.brk   = ($urandom_range(0, 2) == 0);
      rv.irqn  = 1'($urandom);
      rv.iflag = 1'($urandom);
      rv.pcv   = 16'($urandom);
      rv.st    = 8'($urandom);
      rv.sp0   = 8'($urandom);
      rv.kind  = 0;
      if (rv.nmi) begin
        rv.vec  = 16'hFFFA;
        rv.pexp = (rv.st | 8'h20) & 8'hEF;
      end else if (rv.brk) begin
        rv.vec  = 16'hFFFE;
        rv.pexp = rv.st | 8'h30;
      end else if (!rv.irqn && !rv.iflag) begin
        rv.vec  = 16'hFFFE;
        rv.pexp = (rv.st | 8'h20) & 8'hEF;
      end else begin
        rv.kind = 2;
        rv.vec  = 16'h0000;
        rv.pexp = 8'h00;
      end
      run_case($sformatf("rnd%0d", i), rv, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
